nand_rr_scheduler: RTL and testbench

Round-robin scheduler that shares a single WIDTH-bit NAND datapath among NREQ requesters. Each requester presents an operand pair and a request. The block grants one requester at a time, captures its operands, and evaluates the bitwise NAND. It then returns the result, tagged with the requester ID, over a valid/ready result port. It sits between the lab's operand sources and the shared NAND gate bank, and is the only driver of that bank.

---
 rtl/nand_sched_pkg.sv | 20 ++
 rtl/nand2_cell.sv | 12 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/nand_rr_scheduler.sv | 107 ++++++++++
 tb/tb_nand_rr_scheduler.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nand_sched_pkg.sv
// Shared definitions for the round-robin NAND scheduler.
//   state_t     : scheduler FSM encoding
//   OP_COUNT_W  : width of the completed-operation counter
//   id_width()  : bits needed to name one of n requesters
package nand_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int OP_COUNT_W = 16;

   // The result is never narrower than one bit, even for a single requester.
   function automatic int id_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nand2_cell.sv
// Two-input NAND gate cell of the shared gate bank.
//   a, b : inputs
//   y    : ~(a & b)
module nand2_cell (
   input  logic a,
   input  logic b,
   output logic y
);

   assign y = ~(a & b);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : per-requester request
//   rr_ptr : index searched first; the search wraps in ascending order
//   grant  : one-hot grant of the selected requester (0 when none)
//   index  : binary index of the selected requester
//   any    : at least one request is active
module rr_arbiter
   import nand_sched_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]           req,
   input  logic [id_width(NREQ)-1:0] rr_ptr,
   output logic [NREQ-1:0]           grant,
   output logic [id_width(NREQ)-1:0] index,
   output logic                      any
);

   localparam int IW = id_width(NREQ);

   always_comb begin
      int idx;
      // NOTE: every output gets a default before the loop, so no path leaves
      // a value unassigned and no latch is inferred.
      grant = '0;
      index = '0;
      any   = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            index      = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/nand_rr_scheduler.sv
// Round-robin scheduler sharing one WIDTH-bit NAND datapath among NREQ
// requesters. One requester is granted at a time; its operands are captured,
// NANDed, and the result is returned with the requester ID over valid/ready.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : per-requester request (level, held until granted)
//   a_in, b_in : operand pairs, requester i at [i*WIDTH +: WIDTH]
//   gnt        : one-hot grant pulse; operands are sampled in that cycle
//   res_valid  : result available; res_ready : consumer accepts it
//   res_id     : owner of res_data; res_data : ~(A & B)
//   busy       : operation in flight (EXEC or HOLD)
//   op_count   : accepted operations, wraps
module nand_rr_scheduler
   import nand_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     a_in,
   input  logic [NREQ*WIDTH-1:0]     b_in,
   output logic [NREQ-1:0]           gnt,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [id_width(NREQ)-1:0] res_id,
   output logic [WIDTH-1:0]          res_data,
   output logic                      busy,
   output logic [OP_COUNT_W-1:0]     op_count
);

   localparam int IW = id_width(NREQ);

   state_t           state;
   logic [IW-1:0]    rr_ptr;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] nand_y;

   logic [NREQ-1:0]  arb_gnt;
   logic [IW-1:0]    arb_idx;
   logic             arb_any;
   logic [IW-1:0]    ptr_next;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req    (req),
      .rr_ptr (rr_ptr),
      .grant  (arb_gnt),
      .index  (arb_idx),
      .any    (arb_any)
   );

   for (genvar i = 0; i < WIDTH; i++) begin : g_nand
      nand2_cell u_nand (
         .a (op_a[i]),
         .b (op_b[i]),
         .y (nand_y[i])
      );
   end

   // Grants exist only in IDLE; rst also masks them so a held reset never
   // shows a grant even though the arbiter sees live requests.
   assign gnt      = (state == IDLE && !rst) ? arb_gnt : '0;
   assign busy     = (state != IDLE);
   assign ptr_next = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         res_valid <= 1'b0;
         res_id    <= '0;
         res_data  <= '0;
         op_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_any) begin
                  op_a   <= a_in[arb_idx*WIDTH +: WIDTH];
                  op_b   <= b_in[arb_idx*WIDTH +: WIDTH];
                  res_id <= arb_idx;
                  rr_ptr <= ptr_next;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               res_data  <= nand_y;
               res_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  op_count  <= op_count + OP_COUNT_W'(1);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nand_rr_scheduler.sv
module tb_nand_rr_scheduler;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_in;
   logic [NREQ*WIDTH-1:0] b_in;
   logic [NREQ-1:0]       gnt;
   logic                  res_valid;
   logic                  res_ready;
   logic [1:0]            res_id;
   logic [WIDTH-1:0]      res_data;
   logic                  busy;
   logic [15:0]           op_count;

   nand_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_data  (res_data),
      .busy      (busy),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Scoreboard of results owed to the consumer.
   typedef struct {
      int               id;
      logic [WIDTH-1:0] data;
   } exp_t;
   exp_t sb[$];

   // Reference model: phase 0 = free, 1 = computing, 2 = waiting for accept.
   int          m_phase = 0;
   int          m_ptr   = 0;
   int          m_cycle = 0;
   logic [15:0] m_count = '0;
   int          g_cycle[$];
   int          g_id[$];

   always @(negedge clk) begin
      logic [NREQ-1:0] exp_g;
      int              sel;
      bit              found;
      m_cycle++;
      if (rst) begin
         check("rst_gnt", gnt, 0);
         check("rst_valid", res_valid, 0);
         check("rst_id", res_id, 0);
         check("rst_data", res_data, 0);
         check("rst_busy", busy, 0);
         check("rst_count", op_count, 0);
         m_phase = 0;
         m_ptr   = 0;
         m_count = '0;
         sb.delete();
      end else begin
         check("op_count", op_count, m_count);
         check("busy", busy, (m_phase != 0));
         case (m_phase)
            0: begin
               exp_g = '0;
               found = 1'b0;
               sel   = 0;
               for (int k = 0; k < NREQ; k++) begin
                  int idx;
                  idx = (m_ptr + k) % NREQ;
                  if (!found && req[idx]) begin
                     found      = 1'b1;
                     sel        = idx;
                     exp_g[idx] = 1'b1;
                  end
               end
               check("gnt", gnt, exp_g);
               check("valid_idle", res_valid, 0);
               if (found) begin
                  exp_t e;
                  e.id   = sel;
                  e.data = ~(a_in[sel*WIDTH +: WIDTH] & b_in[sel*WIDTH +: WIDTH]);
                  sb.push_back(e);
                  g_cycle.push_back(m_cycle);
                  g_id.push_back(sel);
                  m_ptr   = (sel + 1) % NREQ;
                  m_phase = 1;
               end
            end
            1: begin
               check("gnt_exec", gnt, 0);
               check("valid_exec", res_valid, 0);
               m_phase = 2;
            end
            default: begin
               check("gnt_hold", gnt, 0);
               check("valid_hold", res_valid, 1);
               if (res_ready) begin
                  m_count = m_count + 16'd1;
                  m_phase = 0;
               end
            end
         endcase
      end
   end

   // Result monitor: compares every presented result against the scoreboard
   // head and retires it on the accepting cycle.
   always @(negedge clk) begin
      if (!rst && res_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            check("res_id", res_id, sb[0].id);
            check("res_data", res_data, sb[0].data);
            if (res_ready) void'(sb.pop_front());
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input int budget);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (gnt == '0 && t < budget);
      if (gnt == '0) check("gnt_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   int n0;
   int t_prev;

   initial begin
      rst       = 1'b1;
      req       = '0;
      a_in      = '0;
      b_in      = '0;
      res_ready = 1'b0;
      #1;
      // Reset held with live random inputs.
      for (int i = 0; i < 5; i++) begin
         req  = NREQ'($urandom);
         a_in = $urandom;
         b_in = $urandom;
         cyc(1);
      end
      req = '0;
      rst = 1'b0;
      cyc(1);

      // Single request from requester 1.
      res_ready = 1'b1;
      a_in      = '0;
      b_in      = '0;
      a_in[15:8] = 8'hF0;
      b_in[15:8] = 8'h3C;
      req       = 4'b0010;
      wait_gnt(20);
      req = '0;
      cyc(4);
      check("single_id", g_id[$], 1);
      check("single_count", op_count, 1);

      // Full contention from a fresh pointer.
      reset_pulse();
      n0  = g_id.size();
      req = 4'b1111;
      for (int i = 0; i < 15; i++) begin
         a_in = $urandom;
         b_in = $urandom;
         cyc(1);
      end
      req = '0;
      cyc(4);
      check("cont_grants", (g_id.size() >= n0 + 5), 1);
      if (g_id.size() >= n0 + 5) begin
         for (int j = 0; j < 5; j++) begin
            check("cont_order", g_id[n0+j], j % NREQ);
            if (j > 0) check("cont_spacing", g_cycle[n0+j] - g_cycle[n0+j-1], 3);
         end
      end

      // Backpressure on requester 2.
      res_ready   = 1'b0;
      a_in[23:16] = 8'hFF;
      b_in[23:16] = 8'hFF;
      req         = 4'b0100;
      wait_gnt(20);
      req = '0;
      cyc(6);
      res_ready = 1'b1;
      req       = 4'b0001;
      cyc(2);
      req = '0;
      cyc(4);
      check("bp_id", g_id[$-1], 2);
      check("bp_spacing", g_cycle[$] - g_cycle[$-1], 8);

      // Reset while requester 3 is in EXEC.
      reset_pulse();
      req = 4'b1000;
      wait_gnt(20);
      check("midop_id", g_id[$], 3);
      rst = 1'b1;
      req = 4'b1001;
      cyc(3);
      rst = 1'b0;
      wait_gnt(20);
      check("post_reset_id", g_id[$], 0);
      check("midop_count", op_count, 0);
      req = '0;
      cyc(4);

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 3000; i++) begin
         req       = NREQ'($urandom);
         a_in      = $urandom;
         b_in      = $urandom;
         res_ready = ($urandom_range(0, 9) < 7);
         cyc(1);
      end
      req       = '0;
      res_ready = 1'b1;
      cyc(6);
      check("drain", sb.size(), 0);

      // Counter wrap via preload.
      force dut.op_count = 16'hFFFF;
      m_count = 16'hFFFF;
      cyc(1);
      release dut.op_count;
      cyc(1);
      check("preload", op_count, 16'hFFFF);
      req = 4'b0001;
      wait_gnt(20);
      req = '0;
      cyc(4);
      check("wrap", op_count, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
